// File: rtl/prio_arb_4.sv
// rtl/prio_arb_4.sv - four-requester fixed-priority arbiter with held grants and hold-timeout preemption
// Index 3 wins over 2 over 1 over 0; a grant persists until release or timeout revocation.
module prio_arb_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       pre_q, pre_nxt;
  logic [3:0] others;

  function automatic logic [1:0] pick(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      cnt   <= 8'd0;
      pre_q <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      pre_q <= pre_nxt;
    end
  end

  // Requests other than the current owner; the owner is masked out only for this decision.
  assign others = req & ~(4'b0001 << owner);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    pre_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          owner_nxt = pick(req);
          cnt_nxt   = 8'd0;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          cnt_nxt = 8'd0;
          if (|req) begin
            owner_nxt = pick(req);
          end else begin
            state_nxt = IDLE;
            owner_nxt = 2'd0;
          end
        end else if (TIMEOUT_EN && (cnt == HOLD_LAST) && (|others)) begin
          owner_nxt = pick(others);
          cnt_nxt   = 8'd0;
          pre_nxt   = 1'b1;
        end else if (cnt != HOLD_LAST) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = 2'd0;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign gnt_valid = (state == GRANT);
  assign gnt       = gnt_valid ? (4'b0001 << owner) : 4'b0000;
  assign gnt_id    = gnt_valid ? owner : 2'd0;
  assign preempt   = pre_q;

endmodule

// File: tb/tb_prio_arb_4.sv
// tb/tb_prio_arb_4.sv - self-checking bench for prio_arb_4 with MAX_HOLD=4 and MAX_HOLD=0 instances
// A tenure-length model runs alongside both instances; directed steps also carry literal expectations.
module tb_prio_arb_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt4, gnt0;
  logic [1:0] gnt_id4, gnt_id0;
  logic       gnt_valid4, gnt_valid0;
  logic       preempt4, preempt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_arb_4 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt4), .gnt_id(gnt_id4), .gnt_valid(gnt_valid4), .preempt(preempt4)
  );

  prio_arb_4 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt0), .gnt_id(gnt_id0), .gnt_valid(gnt_valid0), .preempt(preempt0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 idle) and the number of cycles it has shown its grant so far.
  int mh[2] = '{4, 0};
  int m_owner[2] = '{-1, -1};
  int m_held[2]  = '{0, 0};
  int m_pre[2]   = '{0, 0};
  bit started = 1'b0;
  logic [3:0] m_others;

  function automatic int highest(input logic [3:0] v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_pre[k] = 0;
      if (rst) begin
        m_owner[k] = -1;
        m_held[k]  = 0;
      end else if (m_owner[k] < 0) begin
        if (req != 4'b0000) begin
          m_owner[k] = highest(req);
          m_held[k]  = 1;
        end
      end else if (!req[m_owner[k]]) begin
        m_owner[k] = highest(req);
        m_held[k]  = (m_owner[k] < 0) ? 0 : 1;
      end else begin
        m_others = req;
        m_others[m_owner[k]] = 1'b0;
        if (mh[k] != 0 && m_held[k] >= mh[k] && m_others != 4'b0000) begin
          m_owner[k] = highest(m_others);
          m_held[k]  = 1;
          m_pre[k]   = 1;
        end else begin
          m_held[k]++;
        end
      end
    end
    started = 1'b1;
  end

  function automatic logic [31:0] exp_gnt(input int o);
    return (o < 0) ? 32'd0 : (32'd1 << o);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("m4_gnt",    {28'd0, gnt4},       exp_gnt(m_owner[0]));
      check("m4_id",     {30'd0, gnt_id4},    (m_owner[0] < 0) ? 32'd0 : 32'(m_owner[0]));
      check("m4_valid",  {31'd0, gnt_valid4}, {31'd0, m_owner[0] >= 0});
      check("m4_pre",    {31'd0, preempt4},   32'(m_pre[0]));
      check("m0_gnt",    {28'd0, gnt0},       exp_gnt(m_owner[1]));
      check("m0_id",     {30'd0, gnt_id0},    (m_owner[1] < 0) ? 32'd0 : 32'(m_owner[1]));
      check("m0_valid",  {31'd0, gnt_valid0}, {31'd0, m_owner[1] >= 0});
      check("m0_pre",    {31'd0, preempt0},   32'(m_pre[1]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    step(1);
    check("reset_gnt",   {28'd0, gnt4},       32'h0);
    check("reset_id",    {30'd0, gnt_id4},    32'h0);
    check("reset_valid", {31'd0, gnt_valid4}, 32'h0);
    check("reset_pre",   {31'd0, preempt4},   32'h0);

    // Reset with contention
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_hold_gnt", {28'd0, gnt4}, 32'h0);
    end
    rst = 1'b0;
    step(1);
    check("post_rst_gnt",   {28'd0, gnt4},       32'h8);
    check("post_rst_id",    {30'd0, gnt_id4},    32'h3);
    check("post_rst_valid", {31'd0, gnt_valid4}, 32'h1);
    req = 4'b0000;
    step(1);
    check("idle_gnt", {28'd0, gnt4}, 32'h0);

    // Fixed priority and zero-bubble handoff
    req = 4'b0110;
    step(1);
    check("prio_gnt", {28'd0, gnt4},    32'h4);
    check("prio_id",  {30'd0, gnt_id4}, 32'h2);
    req = 4'b0010;
    step(1);
    check("handoff_gnt", {28'd0, gnt4},    32'h2);
    check("handoff_id",  {30'd0, gnt_id4}, 32'h1);
    req = 4'b0000;
    step(1);
    check("release_gnt",   {28'd0, gnt4},       32'h0);
    check("release_valid", {31'd0, gnt_valid4}, 32'h0);

    // Timeout ping-pong with MAX_HOLD=4
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("pp_hold3_gnt", {28'd0, gnt4},     32'h8);
      check("pp_hold3_pre", {31'd0, preempt4}, 32'h0);
    end
    step(1);
    check("pp_to0_gnt", {28'd0, gnt4},     32'h1);
    check("pp_to0_pre", {31'd0, preempt4}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("pp_hold0_gnt", {28'd0, gnt4},     32'h1);
      check("pp_hold0_pre", {31'd0, preempt4}, 32'h0);
    end
    step(1);
    check("pp_to3_gnt", {28'd0, gnt4},     32'h8);
    check("pp_to3_pre", {31'd0, preempt4}, 32'h1);
    check("pp_nolimit_gnt", {28'd0, gnt0}, 32'h8);
    req = 4'b0000;
    step(1);

    // Release coinciding with timeout: release wins
    req = 4'b1001;
    step(4);
    check("sim_pre_gnt", {28'd0, gnt4}, 32'h8);
    req = 4'b0001;
    step(1);
    check("sim_gnt", {28'd0, gnt4},     32'h1);
    check("sim_pre", {31'd0, preempt4}, 32'h0);
    req = 4'b0000;
    step(1);

    // No false preempt
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("solo_gnt", {28'd0, gnt4},     32'h4);
      check("solo_pre", {31'd0, preempt4}, 32'h0);
    end
    req = 4'b0000;
    step(1);

    // Late higher-priority request, MAX_HOLD=0
    req = 4'b0001;
    step(1);
    check("late_own_gnt", {28'd0, gnt0}, 32'h1);
    req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("late_keep_gnt", {28'd0, gnt0}, 32'h1);
    end
    req = 4'b1000;
    step(1);
    check("late_switch_gnt", {28'd0, gnt0},    32'h8);
    check("late_switch_id",  {30'd0, gnt_id0}, 32'h3);
    req = 4'b0000;
    step(1);

    // Reset mid-tenure
    req = 4'b0010;
    step(1);
    check("mid_own_gnt", {28'd0, gnt4}, 32'h2);
    rst = 1'b1;
    step(1);
    check("mid_rst_gnt",   {28'd0, gnt4},       32'h0);
    check("mid_rst_id",    {30'd0, gnt_id4},    32'h0);
    check("mid_rst_valid", {31'd0, gnt_valid4}, 32'h0);
    rst = 1'b0;
    step(1);
    check("mid_regrant_gnt", {28'd0, gnt4}, 32'h2);
    req = 4'b0000;
    step(1);

    // Single-cycle request pulse
    req = 4'b0001;
    step(1);
    check("pulse_gnt", {28'd0, gnt4}, 32'h1);
    req = 4'b0000;
    step(1);
    check("pulse_end_gnt", {28'd0, gnt4}, 32'h0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
